// File: rtl/updown_bounded_counter.sv
// updown_bounded_counter
//   Up/down counter running over a programmable [lo, hi] range with a
//   programmable step, wrap or saturate behaviour at the bounds, load,
//   preset-to-bound, an en-qualified prescaler and bound-crossing flags.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         count enable, advances the prescaler
//   inc_dec    1 = count up, 0 = count down
//   mode       0 = wrap to the opposite bound, 1 = saturate at the bound
//   step       unsigned step magnitude
//   lo, hi     inclusive lower / upper bounds
//   ld, ld_val load ld_val into the counter
//   rst_min    preset counter to lo (wins over rst_max)
//   rst_max    preset counter to hi
//   clr_flags  clear sticky ovf / unf (a same-cycle crossing wins)
//   val        registered counter value
//   at_min     val == lo
//   at_max     val == hi
//   tc         one-cycle pulse after a step that crossed a bound
//   ovf, unf   sticky up / down crossing flags
//   cfg_err    lo > hi; count steps are suppressed while set
module updown_bounded_counter #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              inc_dec,
  input  logic              mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic              ld,
  input  logic [WIDTH-1:0]  ld_val,
  input  logic              rst_min,
  input  logic              rst_max,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  val,
  output logic              at_min,
  output logic              at_max,
  output logic              tc,
  output logic              ovf,
  output logic              unf,
  output logic              cfg_err
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] val_q, val_d;
  logic [PS_W-1:0]  pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             fire;
  logic             up_x, dn_x;

  // Step magnitude zero-extended to the WIDTH+1 arithmetic width.
  function automatic logic [WIDTH:0] ext_step(input logic [STEP_W-1:0] stp);
    logic [WIDTH:0] r;
    r = '0;
    r[STEP_W-1:0] = stp;
    return r;
  endfunction

  // Up step: returns {crossed, next value}. The sum is kept at WIDTH+1 bits
  // so a carry out of WIDTH still counts as passing hi.
  function automatic logic [WIDTH:0] step_up(
    input logic [WIDTH-1:0]  cur,
    input logic [STEP_W-1:0] stp,
    input logic [WIDTH-1:0]  lo_b,
    input logic [WIDTH-1:0]  hi_b,
    input logic              sat
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, cur} + ext_step(stp);
    if (sum > {1'b0, hi_b}) return {1'b1, (sat ? hi_b : lo_b)};
    return {1'b0, sum[WIDTH-1:0]};
  endfunction

  // Down step: returns {crossed, next value}. Signed WIDTH+1 difference so a
  // borrow below zero is seen as passing lo.
  function automatic logic [WIDTH:0] step_dn(
    input logic [WIDTH-1:0]  cur,
    input logic [STEP_W-1:0] stp,
    input logic [WIDTH-1:0]  lo_b,
    input logic [WIDTH-1:0]  hi_b,
    input logic              sat
  );
    logic signed [WIDTH:0] diff;
    diff = $signed({1'b0, cur}) - $signed(ext_step(stp));
    if (diff < $signed({1'b0, lo_b})) return {1'b1, (sat ? lo_b : hi_b)};
    return {1'b0, diff[WIDTH-1:0]};
  endfunction

  assign cfg_err = (lo > hi);
  assign fire    = en && (pre_q == PS_LAST);

  always_comb begin
    val_d = val_q;
    pre_d = pre_q;
    up_x  = 1'b0;
    dn_x  = 1'b0;
    if (rst_min) begin
      val_d = lo;
      pre_d = '0;
    end else if (rst_max) begin
      val_d = hi;
      pre_d = '0;
    end else if (ld) begin
      val_d = ld_val;
      pre_d = '0;
    end else if (en) begin
      pre_d = fire ? '0 : pre_q + 1'b1;
      // A zero step never moves or crosses, even from outside the range.
      if (fire && !cfg_err && (step != '0)) begin
        if (inc_dec) {up_x, val_d} = step_up(val_q, step, lo, hi, mode);
        else         {dn_x, val_d} = step_dn(val_q, step, lo, hi, mode);
      end
    end
    tc_d  = up_x | dn_x;
    // Set beats clear when a crossing coincides with clr_flags.
    ovf_d = up_x | (ovf_q & ~clr_flags);
    unf_d = dn_x | (unf_q & ~clr_flags);
  end

  // Register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q <= '0;
      pre_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      val_q <= val_d;
      pre_q <= pre_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign val    = val_q;
  assign tc     = tc_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign at_min = (val_q == lo);
  assign at_max = (val_q == hi);

endmodule

// File: tb/tb_updown_bounded_counter.sv
module tb_updown_bounded_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, inc_dec, mode, ld, rst_min, rst_max, clr_flags;
  logic [3:0] step;
  logic [7:0] lo, hi, ld_val;

  // Index 0: PRESCALE = 1, index 1: PRESCALE = 3
  logic [7:0] val_o [2];
  logic       amin_o [2], amax_o [2], tc_o [2], ovf_o [2], unf_o [2], cerr_o [2];

  int total = 0;
  int bad   = 0;

  // Reference model state
  int mv [2];
  int mp [2];
  bit mtc [2], movf [2], munf [2];

  always #5 clk = ~clk;

  updown_bounded_counter #(.WIDTH(8), .STEP_W(4), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .inc_dec(inc_dec), .mode(mode),
    .step(step), .lo(lo), .hi(hi), .ld(ld), .ld_val(ld_val),
    .rst_min(rst_min), .rst_max(rst_max), .clr_flags(clr_flags),
    .val(val_o[0]), .at_min(amin_o[0]), .at_max(amax_o[0]), .tc(tc_o[0]),
    .ovf(ovf_o[0]), .unf(unf_o[0]), .cfg_err(cerr_o[0]));

  updown_bounded_counter #(.WIDTH(8), .STEP_W(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .inc_dec(inc_dec), .mode(mode),
    .step(step), .lo(lo), .hi(hi), .ld(ld), .ld_val(ld_val),
    .rst_min(rst_min), .rst_max(rst_max), .clr_flags(clr_flags),
    .val(val_o[1]), .at_min(amin_o[1]), .at_max(amax_o[1]), .tc(tc_o[1]),
    .ovf(ovf_o[1]), .unf(unf_o[1]), .cfg_err(cerr_o[1]));

  // Behavioural model: integer arithmetic on the counting rules.
  function automatic void model_update();
    int v, p, ps, l, h, s;
    bit up, dn;
    for (int k = 0; k < 2; k++) begin
      ps = (k == 0) ? 1 : 3;
      v  = mv[k];
      p  = mp[k];
      l  = int'(lo);
      h  = int'(hi);
      s  = int'(step);
      up = 1'b0;
      dn = 1'b0;
      if (!rst_n) begin
        mv[k] = 0; mp[k] = 0; mtc[k] = 0; movf[k] = 0; munf[k] = 0;
      end else begin
        if (rst_min)      begin v = l; p = 0; end
        else if (rst_max) begin v = h; p = 0; end
        else if (ld)      begin v = int'(ld_val); p = 0; end
        else if (en) begin
          p = p + 1;
          if (p == ps) begin
            p = 0;
            if (l <= h && s != 0) begin
              if (inc_dec) begin
                if (v + s > h) begin up = 1; v = mode ? h : l; end
                else v = v + s;
              end else begin
                if (v - s < l) begin dn = 1; v = mode ? l : h; end
                else v = v - s;
              end
            end
          end
        end
        mv[k]   = v;
        mp[k]   = p;
        mtc[k]  = up | dn;
        movf[k] = up | (movf[k] & !clr_flags);
        munf[k] = dn | (munf[k] & !clr_flags);
      end
    end
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1; ld = 1; ld_val = 8'h55;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({val_o[k], tc_o[k], ovf_o[k], unf_o[k]} !== 11'h000) begin
        bad++;
        $display("FAIL reset[%0d]: got val=%h tc=%b ovf=%b unf=%b, want 00 0 0 0",
                 k, val_o[k], tc_o[k], ovf_o[k], unf_o[k]);
      end
    end
    rst_n = 1; ld = 0; lo = 0; hi = 255; step = 1; inc_dec = 1; mode = 0;
    tick();
    total++;
    if (val_o[0] !== 8'd1) begin
      bad++; $display("FAIL reset_resume: got %0d want 1", val_o[0]);
    end
    total++;
    if (val_o[1] !== 8'd0) begin
      bad++; $display("FAIL reset_resume_ps3: got %0d want 0", val_o[1]);
    end
  endtask

  task automatic test_wrap_up();
    int ev [5] = '{10, 13, 16, 19, 10};
    bit et [5] = '{1, 0, 0, 0, 1};
    lo = 10; hi = 20; step = 3; mode = 0; inc_dec = 1; ld = 1; ld_val = 18; en = 0;
    tick();
    ld = 0;
    total++;
    if (val_o[0] !== 8'd18) begin
      bad++; $display("FAIL wrap_load: got %0d want 18", val_o[0]);
    end
    en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (val_o[0] !== 8'(ev[i]) || tc_o[0] !== et[i]) begin
        bad++;
        $display("FAIL wrap_up[%0d]: got val=%0d tc=%b want val=%0d tc=%b",
                 i, val_o[0], tc_o[0], ev[i], et[i]);
      end
    end
    total++;
    if (ovf_o[0] !== 1'b1) begin
      bad++; $display("FAIL wrap_ovf: got %b want 1", ovf_o[0]);
    end
  endtask

  task automatic test_sat_down();
    lo = 10; hi = 20; step = 4; mode = 1; inc_dec = 0; ld = 1; ld_val = 12; en = 1;
    tick();
    ld = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (val_o[0] !== 8'd10 || tc_o[0] !== 1'b1 || unf_o[0] !== 1'b1 || amin_o[0] !== 1'b1) begin
        bad++;
        $display("FAIL sat_down[%0d]: got val=%0d tc=%b unf=%b at_min=%b want 10 1 1 1",
                 i, val_o[0], tc_o[0], unf_o[0], amin_o[0]);
      end
    end
    en = 0; clr_flags = 1;
    tick();
    total++;
    if (unf_o[0] !== 1'b0 || ovf_o[0] !== 1'b0 || tc_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL clr_flags: got unf=%b ovf=%b tc=%b want 0 0 0", unf_o[0], ovf_o[0], tc_o[0]);
    end
    en = 1;
    tick();
    clr_flags = 0;
    total++;
    if (unf_o[0] !== 1'b1 || tc_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL clr_vs_set: got unf=%b tc=%b want 1 1", unf_o[0], tc_o[0]);
    end
  endtask

  task automatic test_priority();
    lo = 5; hi = 20; ld_val = 99; en = 0;
    rst_min = 1; rst_max = 1; ld = 1;
    tick();
    total++;
    if (val_o[0] !== 8'd5 || amin_o[0] !== 1'b1) begin
      bad++; $display("FAIL prio_min: got val=%0d at_min=%b want 5 1", val_o[0], amin_o[0]);
    end
    rst_min = 0;
    tick();
    total++;
    if (val_o[0] !== 8'd20 || amax_o[0] !== 1'b1) begin
      bad++; $display("FAIL prio_max: got val=%0d at_max=%b want 20 1", val_o[0], amax_o[0]);
    end
    rst_max = 0; ld_val = 7; en = 1; inc_dec = 1; step = 1; mode = 0;
    tick();
    ld = 0;
    total++;
    if (val_o[0] !== 8'd7 || tc_o[0] !== 1'b0) begin
      bad++; $display("FAIL prio_ld_en: got val=%0d tc=%b want 7 0", val_o[0], tc_o[0]);
    end
  endtask

  task automatic test_prescale();
    int ev [6] = '{0, 0, 1, 1, 1, 2};
    lo = 0; hi = 255; step = 1; inc_dec = 1; mode = 0; ld = 1; ld_val = 0; en = 1;
    tick();
    ld = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (val_o[1] !== 8'(ev[i])) begin
        bad++; $display("FAIL prescale[%0d]: got %0d want %0d", i, val_o[1], ev[i]);
      end
    end
    en = 0;
    tick(); tick();
    en = 1;
    tick(); tick();
    total++;
    if (val_o[1] !== 8'd2) begin
      bad++; $display("FAIL prescale_stretch: got %0d want 2", val_o[1]);
    end
    tick();
    total++;
    if (val_o[1] !== 8'd3) begin
      bad++; $display("FAIL prescale_resume: got %0d want 3", val_o[1]);
    end
    tick();
    ld = 1; ld_val = 50;
    tick();
    ld = 0;
    tick(); tick();
    total++;
    if (val_o[1] !== 8'd50) begin
      bad++; $display("FAIL prescale_ld_hold: got %0d want 50", val_o[1]);
    end
    tick();
    total++;
    if (val_o[1] !== 8'd51) begin
      bad++; $display("FAIL prescale_ld_period: got %0d want 51", val_o[1]);
    end
  endtask

  task automatic test_full_range();
    lo = 0; hi = 255; step = 1; mode = 0; inc_dec = 1; ld = 1; ld_val = 255; en = 1;
    tick();
    ld = 0;
    tick();
    total++;
    if (val_o[0] !== 8'd0 || tc_o[0] !== 1'b1 || ovf_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL full_wrap: got val=%0d tc=%b ovf=%b want 0 1 1", val_o[0], tc_o[0], ovf_o[0]);
    end
    lo = 30; hi = 20;
    #1;
    total++;
    if (cerr_o[0] !== 1'b1) begin
      bad++; $display("FAIL cfg_err: got %b want 1", cerr_o[0]);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (val_o[0] !== 8'd0 || tc_o[0] !== 1'b0) begin
        bad++; $display("FAIL cfg_hold[%0d]: got val=%0d tc=%b want 0 0", i, val_o[0], tc_o[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [13:0] obs, exp;
    int a, b;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(19) == 0) begin
        a = $urandom_range(100);
        b = a + $urandom_range(60);
        if ($urandom_range(9) == 0) begin lo = 8'(b); hi = 8'(a); end
        else begin lo = 8'(a); hi = 8'(b); end
      end
      rst_n     = ($urandom_range(59) != 0);
      en        = ($urandom_range(3) != 0);
      inc_dec   = 1'($urandom);
      mode      = 1'($urandom);
      step      = 4'($urandom);
      ld        = ($urandom_range(19) == 0);
      ld_val    = 8'($urandom);
      rst_min   = ($urandom_range(29) == 0);
      rst_max   = ($urandom_range(29) == 0);
      clr_flags = ($urandom_range(9) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        obs = {val_o[k], tc_o[k], ovf_o[k], unf_o[k], amin_o[k], amax_o[k], cerr_o[k]};
        exp = {8'(mv[k]), mtc[k], movf[k], munf[k], (mv[k] == int'(lo)),
               (mv[k] == int'(hi)), (lo > hi)};
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL random[%0d] inst%0d: got {val,tc,ovf,unf,amin,amax,cerr}=%h want %h",
                   n, k, obs, exp);
        end
      end
    end
  endtask

  initial begin
    rst_n = 0; en = 0; inc_dec = 1; mode = 0; step = 0; lo = 0; hi = 0;
    ld = 0; ld_val = 0; rst_min = 0; rst_max = 0; clr_flags = 0;
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0; mp[k] = 0; mtc[k] = 0; movf[k] = 0; munf[k] = 0;
    end
    @(posedge clk); #1;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_priority();
    test_prescale();
    test_full_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_bounded_counter.md
# updown_bounded_counter

Parametrised up/down counter with programmable lower and upper bounds, step size, wrap or saturate mode, load, preset-to-bound, prescaler, and bound-crossing event flags. It is the general-purpose successor to the single-step binary up/down counter. It is used wherever the processor datapath needs loop counters, address walkers or timers that run over an arbitrary range rather than the full 0..2^WIDTH-1.

## Interface
- WIDTH, 8, counter, bound and load-value width
- STEP_W, 4, width of the step-size input
- PRESCALE, 1, number of qualifying en cycles per count step (>=1)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  count enable; qualifies the prescaler
- inc_dec  in  1  direction: 1 = count up, 0 = count down
- mode  in  1  bound behaviour: 0 = wrap to the opposite bound, 1 = saturate at the bound
- step  in  STEP_W  magnitude added or subtracted per count step (unsigned)
- lo  in  WIDTH  lower bound (inclusive)
- hi  in  WIDTH  upper bound (inclusive)
- ld  in  1  load ld_val into the counter
- ld_val  in  WIDTH  load value
- rst_min  in  1  preset counter to lo
- rst_max  in  1  preset counter to hi
- clr_flags  in  1  clear the sticky ovf and unf flags
- val  out  WIDTH  counter value (registered)
- at_min  out  1  val == lo (combinational from registered val and lo)
- at_max  out  1  val == hi (combinational from registered val and hi)
- tc  out  1  one-cycle pulse: a count step crossed a bound (registered)
- ovf  out  1  sticky: an up step crossed hi
- unf  out  1  sticky: a down step crossed lo
- cfg_err  out  1  lo > hi (combinational)

## Operation
- Per-cycle priority, highest first:
  - rst_n = 0: val = 0, prescaler = 0, tc = ovf = unf = 0.
  - rst_min: val = lo.
  - rst_max: val = hi. When rst_min and rst_max are both asserted, rst_min wins.
  - ld: val = ld_val.
  - count step.
- rst_min, rst_max and ld each clear the prescaler and suppress that cycle's count step. tc is 0 in those cycles.
- Prescaler: on each cycle with en = 1 the prescaler increments. On reaching PRESCALE-1 it returns to 0 and a count step fires that cycle. With PRESCALE = 1, every en cycle is a step. When en = 0 the prescaler holds.
- Step arithmetic is done at WIDTH+1 bits, so carry and borrow out of WIDTH are never lost.
  - Up: sum = val + step. If sum > hi, an overflow occurs:
    - wrap: val = lo
    - saturate: val = hi
    - excess beyond the bound is discarded
  - Down: diff = val - step (signed, WIDTH+1). If diff < lo, an underflow occurs:
    - wrap: val = hi
    - saturate: val = lo
  - Otherwise val = sum or diff.
- A step that lands exactly on hi or lo is not a crossing.
- step = 0: val unchanged, never a crossing.
- A val outside [lo, hi] (after a load or a bound change) is counted normally. A crossing is judged only against the comparisons above.
- Crossing effects: tc pulses for one cycle; ovf (up) or unf (down) sets.
  - In saturate mode, a step taken while already at the bound in the counting direction with step > 0 is a crossing every time.
- clr_flags clears ovf and unf. If a crossing occurs in the same cycle, the set wins.
- cfg_err = 1 suppresses count steps; the prescaler still runs. Load and preset still operate.
- mode, inc_dec, step, lo and hi are sampled in the cycle the step fires. They may change on any cycle.

## Timing
- All registered outputs update on the rising edge following the qualifying cycle, a one-cycle latency.
- tc is high for exactly the cycle after the crossing step.
- at_min, at_max and cfg_err are valid in the same cycle as val and lo/hi; there is no extra latency.
- Reset values: val = 0, tc = 0, ovf = 0, unf = 0. at_min and at_max follow val against the bounds.
- Reset asserted mid-count takes effect on the next edge and overrides all other inputs.

## Test plan
- Reset: rst_n = 0 for 2 cycles with en = 1, ld = 1, ld_val = 0x55 -> val = 0x00, tc/ovf/unf = 0. Count resumes on the first cycle after rst_n = 1.
- Wrap up: WIDTH = 8, lo = 10, hi = 20, step = 3, mode = 0, load 18, then en = 1, inc_dec = 1 -> val 18, 10, 13, 16, 19, 10. tc pulses after each 10, and ovf = 1.
- Saturate down: lo = 10, step = 4, mode = 1, load 12, inc_dec = 0 -> val 10 with tc and unf = 1, then stays 10 with tc pulsing each step. clr_flags alone clears unf; clr_flags together with a crossing leaves unf = 1.
- Priority: rst_min, rst_max and ld asserted together with lo = 5 -> val = 5. rst_max with ld -> val = hi. ld = 1 with en = 1 -> val = ld_val and no step.
- Prescale: PRESCALE = 3, en held high, step = 1 -> val advances every 3rd cycle. en low for 2 cycles stretches the period by 2. ld mid-period restarts a full 3-cycle period.
- Full range and config error: lo = 0, hi = 255, step = 1, wrap, val = 255, up -> val = 0 with tc. Then lo = 30, hi = 20 -> cfg_err = 1 and val holds across 10 en cycles.
